// File: rtl/fetch_prefetch_queue_pkg.sv
// ============================================================================
// fetch_prefetch_queue_pkg : shared FSM encoding and default widths
// Revision 1.0
// ============================================================================
`default_nettype none

package fetch_prefetch_queue_pkg;

    localparam int FQ_ADDR_W = 16;
    localparam int FQ_INST_W = 16;
    localparam int FQ_DEPTH  = 4;
    localparam int FQ_PC_INC = 2;

    typedef enum logic [1:0] {
        FQ_IDLE = 2'd0,
        FQ_WAIT = 2'd1,
        FQ_DROP = 2'd2
    } fq_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_prefetch_queue_fq_fifo.sv
// ============================================================================
// fq_fifo : prefetch FIFO with registered head, synchronous flush, count out
// Revision 1.0
// ============================================================================
`default_nettype none

module fq_fifo
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int WIDTH = FQ_INST_W + FQ_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_head;

    logic             w_push;
    logic             w_pop;
    logic [PTR_W-1:0] w_rd_next;
    logic [CNT_W-1:0] w_count_next;

    assign w_push       = push & ~flush & (r_count != C_FULL);
    assign w_pop        = pop & ~flush & (r_count != '0);
    assign w_rd_next    = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Head register tracks the entry that will be at the read pointer next cycle,
    // bypassing the write when the pushed word lands directly at the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            if (w_count_next != '0) begin
                r_head <= (w_push && (r_wr_ptr == w_rd_next)) ? push_data : r_mem[w_rd_next];
            end
        end
    end

    assign head  = r_head;
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
// ============================================================================
// fetch_prefetch_queue : fetch stage with one outstanding memory read and a prefetch FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = FQ_ADDR_W,
    parameter int                INST_W   = FQ_INST_W,
    parameter int                DEPTH    = FQ_DEPTH,
    parameter int                PC_INC   = FQ_PC_INC,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_stall,
    input  logic              mem_done,
    input  logic [INST_W-1:0] mem_data,
    input  logic              mem_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc_next,
    output logic              err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  C_DEPTH  = CNT_W'(DEPTH);
    localparam logic [ADDR_W:0]   C_PC_INC = (ADDR_W + 1)'(PC_INC);

    fq_state_t         r_state;
    fq_state_t         w_state_next;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_active;
    logic              r_err;

    logic [CNT_W-1:0]         w_fifo_count;
    logic [INST_W+ADDR_W-1:0] w_head;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic [ADDR_W:0]          w_pc_sum;

    // Slot is reserved at accept: in IDLE nothing is in flight, so the FIFO
    // occupancy alone is the credit count.
    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        unique case (r_state)
            FQ_IDLE: begin
                mem_req = r_active & ~halt & ~redirect & (w_fifo_count < C_DEPTH);
                if (mem_req && !mem_stall) begin
                    w_state_next = FQ_WAIT;
                end
            end
            FQ_WAIT: begin
                if (mem_done) begin
                    w_state_next = FQ_IDLE;
                end else if (redirect) begin
                    w_state_next = FQ_DROP;
                end
            end
            // The killed response is the only thing we wait for, so its arrival
            // returns to IDLE even if another redirect lands in the same cycle.
            FQ_DROP: begin
                if (mem_done) begin
                    w_state_next = FQ_IDLE;
                end
            end
            default: w_state_next = FQ_IDLE;
        endcase
    end

    assign w_accept = mem_req & ~mem_stall;
    assign w_push   = (r_state == FQ_WAIT) & mem_done & ~redirect;
    assign w_pop    = inst_valid & inst_ready & ~redirect;
    assign w_pc_sum = {1'b0, r_fetch_pc} + C_PC_INC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= FQ_IDLE;
            r_fetch_pc <= RESET_PC;
            r_active   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_active <= 1'b1;
            r_state  <= w_state_next;
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_accept) begin
                r_fetch_pc <= w_pc_sum[ADDR_W-1:0];
            end
            if (w_accept && w_pc_sum[ADDR_W] && (r_fetch_pc != '0)) begin
                r_err <= 1'b1;
            end
            if (w_push && mem_err) begin
                r_err <= 1'b1;
            end
        end
    end

    // While in WAIT the fetch PC already holds request PC + PC_INC.
    fq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W + ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (w_push),
        .push_data ({mem_data, r_fetch_pc}),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_fifo_count)
    );

    assign mem_addr     = r_fetch_pc;
    assign inst_valid   = (w_fifo_count != '0);
    assign inst         = w_head[INST_W+ADDR_W-1:ADDR_W];
    assign inst_pc_next = w_head[ADDR_W-1:0];
    assign err          = r_err;

endmodule

`default_nettype wire
